// File: rtl/active_list_ctrl.sv
// In-order active list: allocates at rename, marks completion from MEM/WB, retires at head,
// and on a mispredict walks younger entries back youngest-first, freeing and restoring mappings.
module active_list_ctrl #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Alloc_Valid,
  input  logic                        i_Alloc_Writes,
  input  logic [REG_ADDR_WIDTH-1:0]   i_Alloc_VAddr,
  input  logic [REG_ADDR_WIDTH:0]     i_Alloc_PAddr,
  input  logic [REG_ADDR_WIDTH:0]     i_Alloc_Old_PAddr,
  output logic                        o_Alloc_Ready,
  output logic [FREE_LIST_WIDTH-1:0]  o_Alloc_Index,
  input  logic                        i_WB_Valid,
  input  logic [FREE_LIST_WIDTH-1:0]  i_WB_Index,
  input  logic                        i_WB_Mispredict,
  output logic                        o_Commit_Valid,
  output logic [REG_ADDR_WIDTH-1:0]   o_Commit_VAddr,
  output logic [REG_ADDR_WIDTH:0]     o_Commit_PAddr,
  output logic                        o_Free_Valid,
  output logic [REG_ADDR_WIDTH:0]     o_Free_PAddr,
  output logic                        o_Restore_Valid,
  output logic [REG_ADDR_WIDTH-1:0]   o_Restore_VAddr,
  output logic [REG_ADDR_WIDTH:0]     o_Restore_PAddr,
  output logic                        o_Flush,
  output logic [FREE_LIST_WIDTH:0]    o_Count
);
  localparam int DEPTH = 1 << FREE_LIST_WIDTH;
  localparam int VW    = REG_ADDR_WIDTH;
  localparam int PW    = REG_ADDR_WIDTH + 1;
  localparam int IW    = FREE_LIST_WIDTH;

  typedef struct packed {
    logic          writes;
    logic [VW-1:0] vaddr;
    logic [PW-1:0] paddr;
    logic [PW-1:0] old_paddr;
  } ent_t;

  typedef enum logic {RUN, ROLLBACK} state_t;

  state_t           state, state_nxt;
  ent_t             ent [DEPTH];
  logic [DEPTH-1:0] vld, done;
  logic [IW-1:0]    head, tail, br_idx, tail_m1;
  logic [IW:0]      count;
  logic             alloc_go, wb_hit, commit_go, mispredict, rb_done, squash;
  ent_t             head_e, tail_e;

  assign tail_m1       = tail - 1'b1;
  assign head_e        = ent[head];
  assign tail_e        = ent[tail_m1];
  assign o_Alloc_Ready = (state == RUN) && (count < (IW+1)'(DEPTH));
  assign o_Alloc_Index = tail;
  assign o_Count       = count;

  assign alloc_go   = i_Alloc_Valid && o_Alloc_Ready;
  assign wb_hit     = (state == RUN) && i_WB_Valid && vld[i_WB_Index];
  assign commit_go  = (state == RUN) && vld[head] && done[head];
  assign mispredict = wb_hit && i_WB_Mispredict;
  // The branch itself stays allocated; the walk stops once it is the youngest entry.
  assign rb_done    = (state == ROLLBACK) && (tail_m1 == br_idx);
  assign squash     = (state == ROLLBACK) && !rb_done;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mispredict) state_nxt = ROLLBACK;
      ROLLBACK: if (rb_done)    state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= RUN;
    else         state <= state_nxt;
  end

  // Entry payload is qualified by vld, so it needs no reset.
  always_ff @(posedge i_Clk) begin
    if (alloc_go)
      ent[tail] <= '{writes: i_Alloc_Writes, vaddr: i_Alloc_VAddr,
                     paddr: i_Alloc_PAddr, old_paddr: i_Alloc_Old_PAddr};
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      br_idx          <= '0;
      vld             <= '0;
      done            <= '0;
      o_Commit_Valid  <= 1'b0;
      o_Commit_VAddr  <= '0;
      o_Commit_PAddr  <= '0;
      o_Free_Valid    <= 1'b0;
      o_Free_PAddr    <= '0;
      o_Restore_Valid <= 1'b0;
      o_Restore_VAddr <= '0;
      o_Restore_PAddr <= '0;
      o_Flush         <= 1'b0;
    end else begin
      o_Commit_Valid  <= 1'b0;
      o_Free_Valid    <= 1'b0;
      o_Restore_Valid <= 1'b0;

      if (wb_hit) done[i_WB_Index] <= 1'b1;
      if (mispredict) begin
        br_idx  <= i_WB_Index;
        o_Flush <= 1'b1;
      end
      if (rb_done) o_Flush <= 1'b0;

      if (commit_go) begin
        vld[head]      <= 1'b0;
        head           <= head + 1'b1;
        o_Commit_Valid <= 1'b1;
        o_Commit_VAddr <= head_e.vaddr;
        o_Commit_PAddr <= head_e.paddr;
        if (head_e.writes) begin
          o_Free_Valid <= 1'b1;
          o_Free_PAddr <= head_e.old_paddr;
        end
      end

      // Allocation comes after completion so a stale done bit at tail is cleared.
      if (alloc_go) begin
        vld[tail]  <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + 1'b1;
      end

      if (squash) begin
        vld[tail_m1] <= 1'b0;
        tail         <= tail_m1;
        if (tail_e.writes) begin
          o_Free_Valid    <= 1'b1;
          o_Free_PAddr    <= tail_e.paddr;
          o_Restore_Valid <= 1'b1;
          o_Restore_VAddr <= tail_e.vaddr;
          o_Restore_PAddr <= tail_e.old_paddr;
        end
      end

      count <= count + (IW+1)'(alloc_go) - (IW+1)'(commit_go) - (IW+1)'(squash);
    end
  end
endmodule

// File: tb/tb_active_list_ctrl.sv
// Bench for active_list_ctrl: queue-based program-order model, directed scenarios with literal
// expectations, then randomized traffic compared against the model every cycle.
module tb_active_list_ctrl;
  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_Alloc_Valid, i_Alloc_Writes;
  logic [4:0] i_Alloc_VAddr;
  logic [5:0] i_Alloc_PAddr, i_Alloc_Old_PAddr;
  logic       o_Alloc_Ready;
  logic [2:0] o_Alloc_Index;
  logic       i_WB_Valid, i_WB_Mispredict;
  logic [2:0] i_WB_Index;
  logic       o_Commit_Valid, o_Free_Valid, o_Restore_Valid, o_Flush;
  logic [4:0] o_Commit_VAddr, o_Restore_VAddr;
  logic [5:0] o_Commit_PAddr, o_Free_PAddr, o_Restore_PAddr;
  logic [3:0] o_Count;

  active_list_ctrl #(.REG_ADDR_WIDTH(5), .FREE_LIST_WIDTH(3)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Alloc_Valid(i_Alloc_Valid), .i_Alloc_Writes(i_Alloc_Writes),
    .i_Alloc_VAddr(i_Alloc_VAddr), .i_Alloc_PAddr(i_Alloc_PAddr),
    .i_Alloc_Old_PAddr(i_Alloc_Old_PAddr),
    .o_Alloc_Ready(o_Alloc_Ready), .o_Alloc_Index(o_Alloc_Index),
    .i_WB_Valid(i_WB_Valid), .i_WB_Index(i_WB_Index), .i_WB_Mispredict(i_WB_Mispredict),
    .o_Commit_Valid(o_Commit_Valid), .o_Commit_VAddr(o_Commit_VAddr),
    .o_Commit_PAddr(o_Commit_PAddr),
    .o_Free_Valid(o_Free_Valid), .o_Free_PAddr(o_Free_PAddr),
    .o_Restore_Valid(o_Restore_Valid), .o_Restore_VAddr(o_Restore_VAddr),
    .o_Restore_PAddr(o_Restore_PAddr),
    .o_Flush(o_Flush), .o_Count(o_Count)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int idx; bit w; int v; int p; int o; bit done;
  } ent_t;

  ent_t q[$];
  int   mtail = 0, bidx = 0;
  bit   rb = 0, eflush = 0, started = 0;
  int   tests = 0, fails = 0;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int find(input int idx);
    foreach (q[i]) if (q[i].idx == idx) return i;
    return -1;
  endfunction

  task automatic idle();
    i_Reset = 0; i_Alloc_Valid = 0; i_Alloc_Writes = 0; i_Alloc_VAddr = 0;
    i_Alloc_PAddr = 0; i_Alloc_Old_PAddr = 0;
    i_WB_Valid = 0; i_WB_Index = 0; i_WB_Mispredict = 0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    int ec = 0, ef = 0, er = 0, ecv = 0, ecp = 0, efp = 0, erv = 0, erp = 0;
    bit cm, rdy;
    int k;
    ent_t e;
    #2;
    if (started && !i_Reset) begin
      chk("alloc_ready", o_Alloc_Ready, (!rb && q.size() < 8));
      chk("alloc_index", o_Alloc_Index, mtail);
    end
    if (i_Reset) begin
      q.delete(); mtail = 0; rb = 0; eflush = 0;
    end else if (!rb) begin
      cm  = q.size() > 0 && q[0].done;
      rdy = q.size() < 8;
      if (cm) begin
        ec = 1; ecv = q[0].v; ecp = q[0].p;
        if (q[0].w) begin ef = 1; efp = q[0].o; end
      end
      if (i_WB_Valid) begin
        k = find(i_WB_Index);
        if (k >= 0) begin
          q[k].done = 1;
          if (i_WB_Mispredict) begin rb = 1; bidx = i_WB_Index; eflush = 1; end
        end
      end
      if (i_Alloc_Valid && rdy) begin
        e.idx = mtail; e.w = i_Alloc_Writes; e.v = i_Alloc_VAddr;
        e.p = i_Alloc_PAddr; e.o = i_Alloc_Old_PAddr; e.done = 0;
        q.push_back(e);
        mtail = (mtail + 1) % 8;
      end
      if (cm) void'(q.pop_front());
    end else begin
      if (q.size() == 0 || q[$].idx == bidx) begin
        rb = 0; eflush = 0;
      end else begin
        e = q.pop_back();
        mtail = (mtail + 7) % 8;
        if (e.w) begin ef = 1; efp = e.p; er = 1; erv = e.v; erp = e.o; end
      end
    end
    @(posedge i_Clk); #1;
    chk("commit_valid", o_Commit_Valid, ec);
    if (ec) begin
      chk("commit_vaddr", o_Commit_VAddr, ecv);
      chk("commit_paddr", o_Commit_PAddr, ecp);
    end
    chk("free_valid", o_Free_Valid, ef);
    if (ef) chk("free_paddr", o_Free_PAddr, efp);
    chk("restore_valid", o_Restore_Valid, er);
    if (er) begin
      chk("restore_vaddr", o_Restore_VAddr, erv);
      chk("restore_paddr", o_Restore_PAddr, erp);
    end
    chk("flush", o_Flush, eflush);
    chk("count", o_Count, q.size());
    started = 1;
  endtask

  task automatic do_reset();
    idle(); i_Reset = 1; tick(); idle();
  endtask

  task automatic alloc(input int v, input int p, input int o);
    idle();
    i_Alloc_Valid = 1; i_Alloc_Writes = 1;
    i_Alloc_VAddr = 5'(v); i_Alloc_PAddr = 6'(p); i_Alloc_Old_PAddr = 6'(o);
    tick(); idle();
  endtask

  task automatic wb(input int idx, input bit mp);
    idle(); i_WB_Valid = 1; i_WB_Index = 3'(idx); i_WB_Mispredict = mp;
    tick(); idle();
  endtask

  task automatic rand_inputs();
    int k;
    i_Reset        = ($urandom % 300) == 0;
    i_Alloc_Valid  = ($urandom % 10) < 6;
    i_Alloc_Writes = ($urandom % 4) != 0;
    i_Alloc_VAddr  = 5'($urandom);
    i_Alloc_PAddr  = 6'($urandom);
    i_Alloc_Old_PAddr = 6'($urandom);
    i_WB_Valid     = ($urandom % 10) < 5;
    if (q.size() > 0 && ($urandom % 4) != 0)
      i_WB_Index = 3'(q[$urandom_range(q.size() - 1, 0)].idx);
    else
      i_WB_Index = 3'($urandom);
    i_WB_Mispredict = ($urandom % 12) == 0;
    k = find(i_WB_Index);
    if (k >= 0 && q[k].done) i_WB_Valid = 0;
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_count", o_Count, 0);
    chk("rst_ready", o_Alloc_Ready, 1);
    chk("rst_flush", o_Flush, 0);

    // In-order retirement of out-of-order completions
    for (int i = 0; i < 3; i++) alloc(i + 1, 33 + i, i + 1);
    wb(2, 0); wb(0, 0);
    wb(1, 0);
    chk("c0_paddr", o_Commit_PAddr, 33); chk("c0_free", o_Free_PAddr, 1);
    tick();
    chk("c1_paddr", o_Commit_PAddr, 34); chk("c1_free", o_Free_PAddr, 2);
    tick();
    chk("c2_paddr", o_Commit_PAddr, 35); chk("c2_free", o_Free_PAddr, 3);
    chk("c2_count", o_Count, 0);

    // Full list, dropped request, refused alloc on commit edge, wrap to index 0
    do_reset();
    for (int i = 0; i < 8; i++) alloc(i, 8 + i, i);
    chk("full_count", o_Count, 8); chk("full_ready", o_Alloc_Ready, 0);
    alloc(20, 60, 20);
    chk("drop_count", o_Count, 8);
    wb(0, 0);
    alloc(21, 61, 21);
    chk("refuse_commit", o_Commit_Valid, 1); chk("refuse_count", o_Count, 7);
    chk("wrap_index", o_Alloc_Index, 0);
    alloc(22, 62, 22);
    chk("wrap_count", o_Count, 8);

    // Mispredict with three younger entries
    do_reset();
    for (int i = 0; i < 5; i++) alloc(i + 1, 40 + i, 10 + i);
    wb(1, 1);
    chk("mp_flush0", o_Flush, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mp_flush", o_Flush, 1);
      chk("mp_free", o_Free_PAddr, 44 - i);
      chk("mp_rvaddr", o_Restore_VAddr, 5 - i);
      chk("mp_rpaddr", o_Restore_PAddr, 14 - i);
    end
    tick();
    chk("mp_end_flush", o_Flush, 0); chk("mp_count", o_Count, 2);
    chk("mp_tail", o_Alloc_Index, 2);

    // Mispredict on youngest; completion during rollback and to an unallocated index
    do_reset();
    alloc(1, 40, 1); alloc(2, 41, 2);
    wb(1, 1);
    chk("ny_flush", o_Flush, 1);
    wb(0, 0);
    chk("ny_flush_end", o_Flush, 0); chk("ny_free", o_Free_Valid, 0);
    wb(5, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ny_nocommit", o_Commit_Valid, 0);
    end
    chk("ny_count", o_Count, 2);

    // Reset in the middle of a rollback walk
    for (int i = 0; i < 3; i++) alloc(i + 3, 50 + i, i);
    wb(0, 1);
    tick();
    do_reset();
    chk("rr_count", o_Count, 0); chk("rr_ready", o_Alloc_Ready, 1);
    chk("rr_flush", o_Flush, 0); chk("rr_free", o_Free_Valid, 0);
    chk("rr_restore", o_Restore_Valid, 0); chk("rr_commit", o_Commit_Valid, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/active_list_ctrl.md
# active_list_ctrl

In-order retirement controller for the renamed pipeline: allocates active-list entries at rename, records completion from the MEM/WB pipeline register (physical write address, active-list index, branch flag), retires entries in program order, and returns freed physical registers to the free list. On a branch mispredict it drives the pipeline flush and walks squashed entries back, one per cycle, restoring rename mappings and freeing their physical registers.

## Interface
- REG_ADDR_WIDTH, 5, architectural (virtual) register address width; physical addresses are REG_ADDR_WIDTH+1 bits
- FREE_LIST_WIDTH, 3, active-list index width; DEPTH = 2^FREE_LIST_WIDTH entries

- i_Clk  in  1  clock; all state changes on rising edge
- i_Reset  in  1  synchronous, active-high reset; highest priority
- i_Alloc_Valid  in  1  rename stage allocates an entry this cycle
- i_Alloc_Writes  in  1  instruction writes a register
- i_Alloc_VAddr  in  REG_ADDR_WIDTH  destination architectural register
- i_Alloc_PAddr  in  REG_ADDR_WIDTH+1  newly mapped physical register
- i_Alloc_Old_PAddr  in  REG_ADDR_WIDTH+1  previous mapping of i_Alloc_VAddr
- o_Alloc_Ready  out  1  combinational: state RUN and count < DEPTH
- o_Alloc_Index  out  FREE_LIST_WIDTH  combinational: tail pointer, the index given to an accepted allocation
- i_WB_Valid  in  1  completion from MEM/WB register
- i_WB_Index  in  FREE_LIST_WIDTH  active-list index of completing instruction
- i_WB_Mispredict  in  1  completing instruction is a mispredicted branch (meaningful only with i_WB_Valid)
- o_Commit_Valid  out  1  registered; one entry retired
- o_Commit_VAddr  out  REG_ADDR_WIDTH  retired destination
- o_Commit_PAddr  out  REG_ADDR_WIDTH+1  retired physical destination
- o_Free_Valid  out  1  registered; return o_Free_PAddr to the free list
- o_Free_PAddr  out  REG_ADDR_WIDTH+1  physical register being freed
- o_Restore_Valid  out  1  registered; rename table must set o_Restore_VAddr to o_Restore_PAddr
- o_Restore_VAddr  out  REG_ADDR_WIDTH
- o_Restore_PAddr  out  REG_ADDR_WIDTH+1
- o_Flush  out  1  registered; flush to all pipeline registers
- o_Count  out  FREE_LIST_WIDTH+1  occupied entries

## Operation
- Per entry: valid, done, writes, VAddr, PAddr, Old_PAddr. Pointers head, tail (mod DEPTH wrap), count 0..DEPTH.
- States: RUN, ROLLBACK. Reset -> RUN.
- Reset: head=tail=count=0, all valid/done cleared, every registered output 0; o_Alloc_Ready=1 after reset. Reset mid-ROLLBACK returns to RUN, empty.
- Allocate (RUN, i_Alloc_Valid && o_Alloc_Ready): write entry[tail], valid=1, done=0; tail+1, count+1. i_Alloc_Valid with ready low is dropped.
- Completion (RUN, i_WB_Valid, entry[i_WB_Index].valid): done=1. Completion to an invalid entry is ignored. All completions ignored in ROLLBACK.
- Commit (RUN only): if entry[head].valid && done: o_Commit_Valid=1 with its VAddr/PAddr; if writes, o_Free_Valid=1, o_Free_PAddr=Old_PAddr; clear valid, head+1, count-1. At most one per cycle.
- Simultaneous allocate and commit: count unchanged. Full with commit same cycle: allocation still refused (ready derived from pre-edge count).
- Mispredict (RUN, valid completion with i_WB_Mispredict): mark branch done, latch index b, -> ROLLBACK, o_Flush<=1. A commit of an older entry at the same edge proceeds.
- ROLLBACK, each edge: if tail-1 == b: -> RUN, o_Flush<=0. Else squash entry e=tail-1: valid=0, tail-1, count-1; if writes: o_Free_Valid=1, o_Free_PAddr=e.PAddr, o_Restore_Valid=1, o_Restore_VAddr=e.VAddr, o_Restore_PAddr=e.Old_PAddr. Walk youngest-first.
- Further mispredicts during ROLLBACK ignored. No allocation or commit in ROLLBACK.
- Pulsed outputs (Commit/Free/Restore valid) are 0 in any cycle without the event.

## Timing
- Allocation accepted at edge A; completion for that index accepted from edge A+1.
- Completion at edge N sets done; commit at edge N+1 if at head; o_Commit_Valid high for the cycle after N+1.
- Mispredict at edge M: o_Flush high from M to the edge that returns to RUN; k younger entries give ROLLBACK lasting k+1 cycles, o_Flush high for k+1 cycles, k free/restore pulses on consecutive cycles.
- Allocation possible again the cycle after return to RUN.

## Test plan
- Reset, allocate 3 writers (VAddr 1,2,3; PAddr 33,34,35; Old 1,2,3); complete indices 2,0,1 -> commits in order 0,1,2 on consecutive cycles, frees 1,2,3, o_Count returns 0.
- Allocate 8 entries -> o_Alloc_Ready=0, o_Count=8; 9th request dropped; same-cycle commit plus alloc on full -> alloc refused, next cycle accepted; tail wraps to index 0.
- Allocate 5, index 1 completes with mispredict -> o_Flush high 4 cycles, frees/restores indices 4,3,2 in that order, tail=2, o_Count=2.
- Mispredict with no younger entries -> ROLLBACK one cycle, no free/restore pulses, o_Flush one cycle.
- Completion to unallocated index, and completion during ROLLBACK -> no done bit set, no commit.
- Assert i_Reset during ROLLBACK -> next cycle all outputs 0, o_Count=0, o_Alloc_Ready=1.
